// File: rtl/r4booth_seqmul.sv
// Sequential radix-4 (modified) Booth multiplier: one Booth digit per cycle,
// valid/ready handshake on both operand and result sides.
module r4booth_seqmul #(
    parameter int PARM_WIDTH = 24,
    localparam int PARM_DIGITS = PARM_WIDTH / 2 + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [PARM_WIDTH-1:0]     opA_i,
    input  logic [PARM_WIDTH-1:0]     opB_i,
    input  logic                      signed_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [2*PARM_WIDTH-1:0]   result_o
);

    localparam int AW = 2 * PARM_WIDTH + 4;
    localparam int BW = PARM_WIDTH + 3;
    localparam int CW = $clog2(PARM_DIGITS + 1);
    localparam logic [CW-1:0] CntLast = CW'(PARM_DIGITS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           a_q;
    logic [BW-1:0]           b_q;
    logic [AW-1:0]           acc_q;
    logic [AW-1:0]           pp;
    logic [CW-1:0]           cnt_q;
    logic [2*PARM_WIDTH-1:0] result_q;
    logic                    accept;
    logic                    finish;
    logic                    sa, sb;

    assign accept = in_valid_i & in_ready_o;
    // One extra BUSY cycle after the last digit moves the sum into result_q.
    assign finish = (state_q == BUSY) && (cnt_q == CntLast);
    assign sa     = signed_i & opA_i[PARM_WIDTH-1];
    assign sb     = signed_i & opB_i[PARM_WIDTH-1];
    assign result_o = result_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (finish) state_d = DONE;
            DONE:    if (out_ready_i) state_d = in_valid_i ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
        out_valid_o = (state_q == DONE);
    end

    // Booth digit is always b_q[2:0]; b_q shifts right and a_q left by 2 per digit.
    always_comb begin
        pp = '0;
        case (b_q[2:0])
            3'b001, 3'b010: pp = a_q;
            3'b011:         pp = a_q << 1;
            3'b100:         pp = ~(a_q << 1) + AW'(1);
            3'b101, 3'b110: pp = ~a_q + AW'(1);
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            a_q   <= {{(AW - PARM_WIDTH){sa}}, opA_i};
            b_q   <= {{2{sb}}, opB_i, 1'b0};
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            if (finish) begin
                result_q <= acc_q[2*PARM_WIDTH-1:0];
            end else begin
                acc_q <= acc_q + pp;
                a_q   <= a_q << 2;
                b_q   <= {{2{b_q[BW-1]}}, b_q[BW-1:2]};
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
